// File: rtl/fir_job_sequencer.sv
// FIR job sequencer: buffers FIR jobs in a small FIFO and, for each job at the
// head of the FIFO, acquires the accelerator, programs source/destination/length,
// triggers it and waits for its end-of-job event before retiring the job.
module fir_job_sequencer #(
  parameter logic [31:0]         BASE_ADDR = 32'h0010_0000,
  parameter int                  DEPTH     = 4,
  parameter int                  ID_WIDTH  = 10,
  parameter logic [ID_WIDTH-1:0] ID_VALUE  = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [31:0]         job_src_i,
  input  logic [31:0]         job_dst_i,
  input  logic [15:0]         job_len_i,
  output logic                done_valid_o,
  output logic [15:0]         done_len_o,
  output logic                busy_o,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic [31:0]         periph_r_data_i,
  input  logic                periph_r_valid_i,
  input  logic                evt_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [31:0] OFS_TRIG   = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFS_SRC    = 32'h0000_0040;
  localparam logic [31:0] OFS_DST    = 32'h0000_0044;
  localparam logic [31:0] OFS_LEN    = 32'h0000_0048;

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    ACQ_RSP,
    WR_SRC,
    WR_DST,
    WR_LEN,
    TRIG,
    WAIT_EVT
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   src_mem [DEPTH];
  logic [31:0]   dst_mem [DEPTH];
  logic [15:0]   len_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          unused_rdata;

  // Only the busy flag of the status word matters when acquiring.
  assign unused_rdata = ^periph_r_data_i[30:0];

  // The head job retires only when the accelerator signals completion. A push
  // is taken whenever there is room after this cycle's retirement, so a full
  // queue that retires and receives a job in the same cycle stays full.
  assign pop         = (state == WAIT_EVT) && evt_i;
  assign job_ready_o = (count < FULL_COUNT);
  assign push        = job_valid_i && (job_ready_o || pop);

  assign busy_o      = (count != '0) || (state != IDLE);
  assign periph_be_o = 4'hF;
  assign periph_id_o = ID_VALUE;

  // Job storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      src_mem[wr_ptr] <= job_src_i;
      dst_mem[wr_ptr] <= job_dst_i;
      len_mem[wr_ptr] <= job_len_i;
    end
  end

  // Queue pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and peripheral request; request fields depend only on state and
  // the head entry, so they hold steady while a request waits for its grant.
  always_comb begin
    state_next    = state;
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_data_o = '0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = ACQ;
        end
      end
      ACQ: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFS_STATUS;
        periph_wen_o = 1'b1;
        if (periph_gnt_i) begin
          state_next = ACQ_RSP;
        end
      end
      ACQ_RSP: begin
        if (periph_r_valid_i) begin
          state_next = periph_r_data_i[31] ? ACQ : WR_SRC;
        end
      end
      WR_SRC: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + OFS_SRC;
        periph_data_o = src_mem[rd_ptr];
        if (periph_gnt_i) begin
          state_next = WR_DST;
        end
      end
      WR_DST: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + OFS_DST;
        periph_data_o = dst_mem[rd_ptr];
        if (periph_gnt_i) begin
          state_next = WR_LEN;
        end
      end
      WR_LEN: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + OFS_LEN;
        periph_data_o = {16'h0000, len_mem[rd_ptr]};
        if (periph_gnt_i) begin
          state_next = TRIG;
        end
      end
      TRIG: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFS_TRIG;
        if (periph_gnt_i) begin
          state_next = WAIT_EVT;
        end
      end
      WAIT_EVT: begin
        if (evt_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Completion pulse carries the length of the job that just retired.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_valid_o <= 1'b0;
      done_len_o   <= '0;
    end else begin
      done_valid_o <= pop;
      if (pop) begin
        done_len_o <= len_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fir_job_sequencer.sv
// Testbench for fir_job_sequencer: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a transaction-level
// model of the job queue and the accelerator programming sequence.
module tb_fir_job_sequencer;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 4;
  localparam int          IDW   = 10;

  localparam int P_NONE = 0;
  localparam int P_ACQ  = 1;
  localparam int P_RSP  = 2;
  localparam int P_SRC  = 3;
  localparam int P_DST  = 4;
  localparam int P_LEN  = 5;
  localparam int P_TRIG = 6;
  localparam int P_WAIT = 7;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } job_t;

  typedef struct {
    logic        valid;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        evt;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] done_len;
  } vec_t;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           job_valid_i;
  logic           job_ready_o;
  logic [31:0]    job_src_i;
  logic [31:0]    job_dst_i;
  logic [15:0]    job_len_i;
  logic           done_valid_o;
  logic [15:0]    done_len_o;
  logic           busy_o;
  logic           periph_req_o;
  logic           periph_gnt_i;
  logic [31:0]    periph_add_o;
  logic           periph_wen_o;
  logic [3:0]     periph_be_o;
  logic [31:0]    periph_data_o;
  logic [IDW-1:0] periph_id_o;
  logic [31:0]    periph_r_data_i;
  logic           periph_r_valid_i;
  logic           evt_i;

  int tests_run    = 0;
  int tests_failed = 0;

  job_t        mq[$];
  int          phase = P_NONE;
  logic        exp_done = 1'b0;
  logic [15:0] exp_done_len = '0;
  logic [15:0] got_done[$];

  logic        nxt_valid = 1'b0;
  job_t        nxt_job;
  logic        nxt_evt = 1'b0;
  bit          gnt_random = 1'b0;
  bit          rsp_random = 1'b0;
  int          gnt_low_cnt = 0;
  logic [31:0] acq_q[$];
  bit          rd_pending = 1'b0;
  int          rd_wait = 0;
  int          acq_reads = 0;
  int          dst_writes = 0;
  int          dst_cycles = 0;

  vec_t vecs[11];

  fir_job_sequencer #(
    .BASE_ADDR(BASE),
    .DEPTH(DEPTH),
    .ID_WIDTH(IDW),
    .ID_VALUE('0)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .job_valid_i(job_valid_i),
    .job_ready_o(job_ready_o),
    .job_src_i(job_src_i),
    .job_dst_i(job_dst_i),
    .job_len_i(job_len_i),
    .done_valid_o(done_valid_o),
    .done_len_o(done_len_o),
    .busy_o(busy_o),
    .periph_req_o(periph_req_o),
    .periph_gnt_i(periph_gnt_i),
    .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o),
    .periph_be_o(periph_be_o),
    .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o),
    .periph_r_data_i(periph_r_data_i),
    .periph_r_valid_i(periph_r_valid_i),
    .evt_i(evt_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Hard stop in case the DUT stalls somewhere the bounded waits do not cover.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion by 1ms, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    job_valid_i      = nxt_valid;
    job_src_i        = nxt_job.src;
    job_dst_i        = nxt_job.dst;
    job_len_i        = nxt_job.len;
    evt_i            = nxt_evt;
    periph_r_valid_i = 1'b0;
    periph_r_data_i  = $urandom;
    if (gnt_low_cnt > 0) begin
      periph_gnt_i = 1'b0;
      gnt_low_cnt--;
    end else begin
      periph_gnt_i = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (rd_pending) begin
      if (rd_wait == 0) begin
        rd_pending       = 1'b0;
        periph_r_valid_i = 1'b1;
        if (acq_q.size() > 0) begin
          periph_r_data_i = acq_q.pop_front();
        end else if (rsp_random) begin
          periph_r_data_i = {($urandom_range(0, 2) == 0), 31'($urandom)};
        end else begin
          periph_r_data_i = 32'h0;
        end
      end else begin
        rd_wait--;
      end
    end
  endtask

  // Checks the outputs against the model, then advances the model by the
  // effect of the coming clock edge given the inputs currently applied.
  task automatic modelStep();
    logic [31:0] ea;
    logic        ew;
    logic [31:0] ed;
    bit          req_phase;
    bit          hs;
    bit          popping;
    job_t        j;
    checkOutput("ready", 32'(job_ready_o), 32'(mq.size() < DEPTH));
    checkOutput("busy", 32'(busy_o), 32'(mq.size() != 0));
    checkOutput("be", 32'(periph_be_o), 32'hF);
    checkOutput("id", 32'(periph_id_o), 32'h0);
    checkOutput("done_valid", 32'(done_valid_o), 32'(exp_done));
    if (exp_done) checkOutput("done_len", 32'(done_len_o), 32'(exp_done_len));
    if (done_valid_o) got_done.push_back(done_len_o);
    req_phase = 1'b1;
    ea = BASE;
    ew = 1'b0;
    ed = 32'h0;
    case (phase)
      P_ACQ:   begin ea = BASE + 32'h04; ew = 1'b1; end
      P_SRC:   begin ea = BASE + 32'h40; ed = mq[0].src; end
      P_DST:   begin ea = BASE + 32'h44; ed = mq[0].dst; end
      P_LEN:   begin ea = BASE + 32'h48; ed = {16'h0, mq[0].len}; end
      P_TRIG:  begin ea = BASE; ed = 32'h0; end
      default: req_phase = 1'b0;
    endcase
    if (phase != P_ACQ) checkOutput("req", 32'(periph_req_o), 32'(req_phase));
    if (periph_req_o && req_phase) begin
      checkOutput("add", periph_add_o, ea);
      checkOutput("wen", 32'(periph_wen_o), 32'(ew));
      if (phase != P_ACQ) checkOutput("data", periph_data_o, ed);
    end
    if (periph_req_o && periph_add_o == BASE + 32'h44) dst_cycles++;
    hs = periph_req_o && periph_gnt_i && req_phase;
    popping = (phase == P_WAIT) && evt_i;
    exp_done = popping;
    if (popping) begin
      exp_done_len = mq[0].len;
      void'(mq.pop_front());
      phase = P_NONE;
    end
    if (phase == P_RSP && periph_r_valid_i) phase = periph_r_data_i[31] ? P_ACQ : P_SRC;
    if (hs) begin
      case (phase)
        P_ACQ: begin
          phase = P_RSP;
          acq_reads++;
          rd_pending = 1'b1;
          rd_wait = rsp_random ? $urandom_range(0, 2) : 0;
        end
        P_SRC:  phase = P_DST;
        P_DST:  begin phase = P_LEN; dst_writes++; end
        P_LEN:  phase = P_TRIG;
        P_TRIG: phase = P_WAIT;
        default: phase = phase;
      endcase
    end
    if (job_valid_i && mq.size() < DEPTH) begin
      j.src = job_src_i;
      j.dst = job_dst_i;
      j.len = job_len_i;
      mq.push_back(j);
    end
    if (phase == P_NONE && mq.size() != 0) phase = P_ACQ;
  endtask

  task automatic runCycle();
    @(posedge clk_i);
    #1;
    applyStimulus();
    @(negedge clk_i);
    modelStep();
  endtask

  task automatic pushJob(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    nxt_valid   = 1'b1;
    nxt_job.src = src;
    nxt_job.dst = dst;
    nxt_job.len = len;
    runCycle();
    nxt_valid = 1'b0;
  endtask

  task automatic waitPhase(input int target, input int budget, input string name);
    int n = 0;
    while (phase != target && n < budget) begin
      runCycle();
      n++;
    end
    checkOutput({name, "_reached"}, 32'(phase == target), 32'd1);
  endtask

  task automatic doEvt(input string name);
    waitPhase(P_WAIT, 60, name);
    nxt_evt = 1'b1;
    runCycle();
    nxt_evt = 1'b0;
    runCycle();
  endtask

  task automatic doReset();
    @(posedge clk_i);
    #3;
    rst_i            = 1'b1;
    job_valid_i      = 1'b0;
    evt_i            = 1'b0;
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b0;
    periph_r_data_i  = 32'h0;
    #1;
    checkOutput("rst_ready", 32'(job_ready_o), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_req", 32'(periph_req_o), 32'd0);
    checkOutput("rst_done", 32'(done_valid_o), 32'd0);
    checkOutput("rst_done_len", 32'(done_len_o), 32'd0);
    checkOutput("rst_add", periph_add_o, 32'd0);
    checkOutput("rst_wen", 32'(periph_wen_o), 32'd0);
    checkOutput("rst_data", periph_data_o, 32'd0);
    checkOutput("rst_be", 32'(periph_be_o), 32'hF);
    mq.delete();
    acq_q.delete();
    phase       = P_NONE;
    exp_done    = 1'b0;
    rd_pending  = 1'b0;
    gnt_low_cnt = 0;
    nxt_valid   = 1'b0;
    nxt_evt     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic driveRow(input vec_t v);
    job_valid_i      = v.valid;
    job_src_i        = v.src;
    job_dst_i        = v.dst;
    job_len_i        = v.len;
    periph_gnt_i     = v.gnt;
    periph_r_valid_i = v.rvalid;
    periph_r_data_i  = v.rdata;
    evt_i            = v.evt;
  endtask

  // Main test sequence.
  initial begin
    rst_i = 1'b0;
    job_valid_i = 1'b0;
    job_src_i = '0;
    job_dst_i = '0;
    job_len_i = '0;
    periph_gnt_i = 1'b0;
    periph_r_valid_i = 1'b0;
    periph_r_data_i = '0;
    evt_i = 1'b0;
    nxt_job.src = '0;
    nxt_job.dst = '0;
    nxt_job.len = '0;

    //           valid src       dst       len    gnt rv rdata         evt  req add           wen data      rdy busy done dlen
    vecs[0]  = '{1'b1, 32'h1000, 32'h2000, 16'd64, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0010_0004, 1'b1, 32'h0,   1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0010_0040, 1'b0, 32'h1000, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0010_0044, 1'b0, 32'h2000, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0010_0048, 1'b0, 32'd64,   1'b1, 1'b1, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0010_0000, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 16'd64};
    vecs[10] = '{1'b0, 32'h0,    32'h0,    16'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 16'd0};

    doReset();

    // Single job with minimum latency, evt ignored outside WAIT_EVT.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk_i);
      #1;
      driveRow(vecs[i]);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d_req", i), 32'(periph_req_o), 32'(vecs[i].req));
      checkOutput($sformatf("vec%0d_add", i), periph_add_o, vecs[i].add);
      checkOutput($sformatf("vec%0d_wen", i), 32'(periph_wen_o), 32'(vecs[i].wen));
      checkOutput($sformatf("vec%0d_data", i), periph_data_o, vecs[i].data);
      checkOutput($sformatf("vec%0d_ready", i), 32'(job_ready_o), 32'(vecs[i].ready));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_done", i), 32'(done_valid_o), 32'(vecs[i].done));
      if (vecs[i].done) checkOutput($sformatf("vec%0d_done_len", i), 32'(done_len_o), 32'(vecs[i].done_len));
      modelStep();
    end
    rd_pending = 1'b0;

    // Accelerator reports busy twice before it can be programmed.
    acq_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    acq_reads = 0;
    pushJob(32'hA000, 32'hB000, 16'd7);
    waitPhase(P_WAIT, 60, "busy_acq");
    checkOutput("acq_reads", 32'(acq_reads), 32'd3);
    doEvt("busy_acq_evt");

    // Fifth push into a full queue is dropped; completions follow push order.
    got_done.delete();
    for (int k = 0; k < 5; k++) pushJob(32'h3000 + 32'(k * 16), 32'h4000 + 32'(k * 16), 16'(10 + k));
    runCycle();
    checkOutput("full_ready", 32'(job_ready_o), 32'd0);
    for (int k = 0; k < 4; k++) doEvt("fill_evt");
    checkOutput("fill_done_count", 32'(got_done.size()), 32'd4);
    for (int k = 0; k < 4 && k < got_done.size(); k++) checkOutput("fill_done_order", 32'(got_done[k]), 32'(10 + k));
    checkOutput("fill_idle", 32'(busy_o), 32'd0);

    // Grant withheld for three cycles while programming the destination.
    dst_writes = 0;
    dst_cycles = 0;
    pushJob(32'h5000, 32'h6000, 16'd9);
    waitPhase(P_DST, 30, "wr_dst");
    gnt_low_cnt = 3;
    waitPhase(P_LEN, 30, "wr_dst_done");
    checkOutput("dst_cycles", 32'(dst_cycles), 32'd4);
    checkOutput("dst_writes", 32'(dst_writes), 32'd1);
    doEvt("wr_dst_evt");

    // Reset while waiting on the accelerator with three jobs queued.
    got_done.delete();
    for (int k = 0; k < 3; k++) pushJob(32'h7000, 32'h8000, 16'(30 + k));
    waitPhase(P_WAIT, 60, "rst_wait");
    runCycle();
    doReset();
    nxt_evt = 1'b1;
    repeat (3) runCycle();
    nxt_evt = 1'b0;
    checkOutput("rst_no_done", 32'(got_done.size()), 32'd0);
    pushJob(32'h9000, 32'h9100, 16'd0);
    doEvt("post_rst_evt");
    checkOutput("post_rst_done_count", 32'(got_done.size()), 32'd1);

    // Push into a full queue on the same cycle as a completion.
    got_done.delete();
    for (int k = 0; k < 4; k++) pushJob(32'hC000 + 32'(k), 32'hD000 + 32'(k), 16'(20 + k));
    waitPhase(P_WAIT, 60, "swap_wait");
    checkOutput("swap_full_before", 32'(job_ready_o), 32'd0);
    nxt_evt     = 1'b1;
    nxt_valid   = 1'b1;
    nxt_job.src = 32'hC004;
    nxt_job.dst = 32'hD004;
    nxt_job.len = 16'd24;
    runCycle();
    nxt_evt   = 1'b0;
    nxt_valid = 1'b0;
    runCycle();
    checkOutput("swap_full_after", 32'(job_ready_o), 32'd0);
    for (int k = 0; k < 4; k++) doEvt("swap_evt");
    checkOutput("swap_done_count", 32'(got_done.size()), 32'd5);
    for (int k = 0; k < 5 && k < got_done.size(); k++) checkOutput("swap_done_order", 32'(got_done[k]), 32'(20 + k));

    // Randomized traffic, grants, acquire responses and events.
    gnt_random = 1'b1;
    rsp_random = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      nxt_valid   = ($urandom_range(0, 2) == 0);
      nxt_job.src = $urandom;
      nxt_job.dst = $urandom;
      nxt_job.len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      nxt_evt     = ($urandom_range(0, 3) == 0);
      runCycle();
    end
    nxt_valid = 1'b0;
    for (int g = 0; g < 2000 && mq.size() != 0; g++) begin
      nxt_evt = (phase == P_WAIT);
      runCycle();
    end
    nxt_evt = 1'b0;
    runCycle();
    runCycle();
    checkOutput("drain_empty", 32'(mq.size()), 32'd0);
    checkOutput("drain_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_job_sequencer.md
FIR_JOB_SEQUENCER -- requirements
Module: fir_job_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0010_0000, FIR accelerator peripheral base address.
REQ-002 SHALL have parameter DEPTH, default 4, job queue entries (power of two, >=2).
REQ-003 SHALL have parameter ID_WIDTH, default 10, peripheral transaction ID width.
REQ-004 SHALL have parameter ID_VALUE, default 0, constant ID driven on every peripheral request.
REQ-005 SHALL have ports (one clock; reset asynchronous, active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- job_valid_i  in  1  job push request
- job_ready_o  out  1  queue not full
- job_src_i  in  32  input buffer address
- job_dst_i  in  32  output buffer address
- job_len_i  in  16  sample count
- done_valid_o  out  1  one-cycle job-completion pulse
- done_len_o  out  16  length of the completed job
- busy_o  out  1  queue non-empty or FSM not IDLE
- periph_req_o  out  1  peripheral request
- periph_gnt_i  in  1  peripheral grant
- periph_add_o  out  32  peripheral address
- periph_wen_o  out  1  0=write, 1=read
- periph_be_o  out  4  byte enables, always 4'hF
- periph_data_o  out  32  write data
- periph_id_o  out  ID_WIDTH  transaction ID
- periph_r_data_i  in  32  read data
- periph_r_valid_i  in  1  read response valid
- evt_i  in  1  accelerator end-of-job event

Function
REQ-006 Queue SHALL accept a job when job_valid_i && job_ready_o; job_ready_o = (count < DEPTH).
REQ-007 Push and pop in the same cycle SHALL keep count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-008 FSM states SHALL be IDLE, ACQ, ACQ_RSP, WR_SRC, WR_DST, WR_LEN, TRIG, WAIT_EVT.
REQ-009 IDLE -> ACQ when queue non-empty; the head entry is not popped until WAIT_EVT completes.
REQ-010 ACQ: read (wen=1) at BASE_ADDR+0x04; on gnt -> ACQ_RSP.
REQ-011 ACQ_RSP: on r_valid, r_data[31]=1 (accelerator busy) -> ACQ; else -> WR_SRC.
REQ-012 WR_SRC/WR_DST/WR_LEN SHALL write (wen=0) job_src to +0x40, job_dst to +0x44, zero-extended job_len to +0x48, advancing on gnt.
REQ-013 TRIG SHALL write 0 to BASE_ADDR+0x00, then -> WAIT_EVT on gnt.
REQ-014 periph_req_o SHALL be 1 only in ACQ, WR_*, TRIG; address/data/wen SHALL hold stable while req=1 and gnt=0.
REQ-015 WAIT_EVT: on evt_i, pop head, pulse done_valid_o for 1 cycle with done_len_o = popped length, -> IDLE.
REQ-016 evt_i outside WAIT_EVT SHALL be ignored.
REQ-017 A push while the queue is full SHALL be dropped without corrupting state.
REQ-018 Minimum latency, queue non-empty to first req: 1 cycle; with gnt tied high and immediate r_valid, to trigger grant: 6 cycles.
REQ-019 Zero-length jobs SHALL be programmed unchanged; the sequencer SHALL not validate lengths.

Reset
REQ-020 rst_i asserted SHALL immediately set FSM=IDLE, count=0, pointers=0, and all outputs 0 except job_ready_o=1 and periph_be_o=4'hF.
REQ-021 Reset mid-transaction SHALL drop the outstanding request and discard all queued jobs; no done pulse is emitted.

Verification
REQ-022 Single job src=0x1000, dst=0x2000, len=64, gnt high, acquire r_data=0 -> writes 0x1000@+0x40, 0x2000@+0x44, 64@+0x48, 0@+0x00; evt -> done_valid=1, done_len=64.
REQ-023 Acquire r_data=0xFFFF_FFFF twice, then 0 -> three acquire reads, then normal programming.
REQ-024 Push 5 jobs with no evt -> job_ready_o=0 after the 4th (DEPTH=4), 5th dropped; 4 evts -> 4 done pulses in push order.
REQ-025 gnt held low 3 cycles during WR_DST -> address 0x...44 and data stable all 4 cycles, single write accepted.
REQ-026 rst_i asserted in WAIT_EVT with 3 jobs queued -> job_ready_o=1, busy_o=0, periph_req_o=0; subsequent evt produces no done pulse.
REQ-027 Push on the same cycle as pop with a full queue -> count stays DEPTH, order preserved.
